btb_bimodal_predictor: RTL and testbench
========================================

Name: btb_bimodal_predictor

Overview:
Parametrised branch target buffer with per-entry saturating direction counters for the 5-stage pipeline. It predicts taken branches in IF, so a correctly predicted branch no longer flushes IF/ID and ID/EXE. It is updated from EXE with the resolved outcome and reports mispredictions, redirect addresses and saturating statistics. It sits beside the program counter, looked up with the fetch PC and trained from the ALU branch-resolution outputs.

Parameters:
ADDR_W, 32, instruction address width in bits.
ENTRIES, 16, number of BTB entries; power of two, minimum 2; IDX_W = clog2(ENTRIES).
CTR_W, 2, direction counter width; minimum 1.
CNT_W, 16, statistics counter width.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  reset, asynchronous, active-low.
if_pc  in  ADDR_W  fetch PC for lookup.
pred_taken  out  1  prediction for if_pc; combinational.
pred_target  out  ADDR_W  predicted next PC; combinational.
upd_valid  in  1  a branch resolved in EXE this cycle.
upd_pc  in  ADDR_W  PC of the resolved branch.
upd_taken  in  1  actual direction.
upd_target  in  ADDR_W  actual taken target.
upd_pred_taken  in  1  prediction carried down the pipe with the branch.
upd_pred_target  in  ADDR_W  predicted target carried with the branch.
mispredict  out  1  flush request; combinational.
redirect_addr  out  ADDR_W  correct next PC when mispredict=1.
branch_count  out  CNT_W  resolved branches, saturating.
mispred_count  out  CNT_W  mispredictions, saturating.

Behaviour:
- Entry fields: valid, tag, target[ADDR_W], ctr[CTR_W].
- Index = pc[IDX_W+1:2]. Tag = pc[ADDR_W-1:IDX_W+2]. pc[1:0] is ignored.
- Lookup (combinational):
  - hit = valid & (tag match at the index).
  - pred_taken = hit & ctr[CTR_W-1].
  - pred_target = pred_taken ? entry target : if_pc+4, computed modulo 2^ADDR_W.
- mispredict = upd_valid & ((upd_pred_taken != upd_taken) | (upd_taken & upd_pred_taken & (upd_pred_target != upd_target))).
- redirect_addr = upd_taken ? upd_target : upd_pc+4. The value is don't-care when mispredict=0, but the output is still driven.
- Update on the rising edge when upd_valid=1:
  - Hit, taken: ctr increments, saturating at all-ones; target is overwritten with upd_target.
  - Hit, not taken: ctr decrements, saturating at 0; target is kept.
  - Miss, taken: allocate or replace the entry at the index. valid=1, tag and target are written, ctr = 1<<(CTR_W-1) (weakly taken).
  - Miss, not taken: no state change.
- No bypass: a lookup in the same cycle as an update to the same index sees the pre-update contents. The new contents are visible from the next cycle.
- Statistics:
  - branch_count increments on every upd_valid.
  - mispred_count increments on every mispredict.
  - Both hold at 2^CNT_W-1 once reached; there is no wrap.
- Reset (rst=0, asynchronous):
  - All valid=0, all ctr=0, targets and tags=0, both counters=0.
  - Outputs immediately become pred_taken=0 and pred_target=if_pc+4.
  - Counters read 0 during reset and in the first cycle after deassertion.
- Updates with upd_valid=0 are ignored regardless of the other upd_* values.
- Storage is flops; no memory macro is used.
- The pipeline integration, not this block, gates updates during stall.

Test Plan:
- Reset: rst=0 mid-run with entries populated -> pred_taken=0 for all PCs, pred_target=if_pc+4, branch_count=mispred_count=0 asynchronously.
- Cold miss then allocate: if_pc=0x40 gives pred_taken=0, pred_target=0x44. Update with upd_pc=0x40, taken, target 0x100, pred_taken=0 -> mispredict=1, redirect_addr=0x100. Next cycle if_pc=0x40 -> pred_taken=1, pred_target=0x100.
- Hysteresis (CTR_W=2):
  - From weakly taken, one not-taken update -> ctr=01, pred_taken=0.
  - Two taken updates -> ctr=11.
  - One not-taken update -> ctr=10, still predicts taken.
  - Repeated taken updates at 11 stay at 11.
- Aliasing, ENTRIES=16: 0x40 allocated, then 0x440 resolves taken to 0x200 -> entry replaced; 0x40 now misses, pred_target=0x44; 0x440 predicts 0x200.
- Wrong target: entry for 0x80 predicts 0x300, branch resolves taken to 0x380 with upd_pred_taken=1 -> mispredict=1, redirect_addr=0x380; target updated next cycle.
- Counter saturation and same-cycle conflict:
  - CNT_W=4, 20 mispredicting updates -> mispred_count=15, branch_count=15.
  - Update and lookup on the same index in one cycle -> the lookup returns old data.

Source files
------------

// File: rtl/btb_bimodal_predictor.sv
// Direct-mapped branch target buffer with per-entry saturating direction counters.
// Looked up combinationally from IF, trained from EXE, with saturating statistics.
module btb_bimodal_predictor #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned ENTRIES = 16,
    parameter int unsigned CTR_W   = 2,
    parameter int unsigned CNT_W   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] if_pc,
    output logic              pred_taken,
    output logic [ADDR_W-1:0] pred_target,
    input  logic              upd_valid,
    input  logic [ADDR_W-1:0] upd_pc,
    input  logic              upd_taken,
    input  logic [ADDR_W-1:0] upd_target,
    input  logic              upd_pred_taken,
    input  logic [ADDR_W-1:0] upd_pred_target,
    output logic              mispredict,
    output logic [ADDR_W-1:0] redirect_addr,
    output logic [CNT_W-1:0]  branch_count,
    output logic [CNT_W-1:0]  mispred_count
);

    localparam int unsigned IDX_W = $clog2(ENTRIES);
    localparam int unsigned TAG_W = ADDR_W - IDX_W - 2;
    localparam logic [CTR_W-1:0] CtrWeak = CTR_W'(1) << (CTR_W - 1);

    logic              valid_q  [ENTRIES];
    logic [TAG_W-1:0]  tag_q    [ENTRIES];
    logic [ADDR_W-1:0] target_q [ENTRIES];
    logic [CTR_W-1:0]  ctr_q    [ENTRIES];

    logic [IDX_W-1:0] lk_idx;
    logic [TAG_W-1:0] lk_tag;
    logic             lk_hit;
    logic [IDX_W-1:0] up_idx;
    logic [TAG_W-1:0] up_tag;
    logic             up_hit;

    always_comb begin
        lk_idx      = if_pc[IDX_W+1:2];
        lk_tag      = if_pc[ADDR_W-1:IDX_W+2];
        lk_hit      = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
        pred_taken  = lk_hit && ctr_q[lk_idx][CTR_W-1];
        pred_target = pred_taken ? target_q[lk_idx] : if_pc + ADDR_W'(4);
    end

    always_comb begin
        up_idx        = upd_pc[IDX_W+1:2];
        up_tag        = upd_pc[ADDR_W-1:IDX_W+2];
        up_hit        = valid_q[up_idx] && (tag_q[up_idx] == up_tag);
        // A wrong target only matters when both prediction and outcome are taken.
        mispredict    = upd_valid && ((upd_pred_taken != upd_taken) ||
                        (upd_taken && upd_pred_taken && (upd_pred_target != upd_target)));
        redirect_addr = upd_taken ? upd_target : upd_pc + ADDR_W'(4);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= '0;
            end
            branch_count  <= '0;
            mispred_count <= '0;
        end else if (upd_valid) begin
            if (up_hit) begin
                if (upd_taken) begin
                    if (ctr_q[up_idx] != '1) begin
                        ctr_q[up_idx] <= ctr_q[up_idx] + CTR_W'(1);
                    end
                    target_q[up_idx] <= upd_target;
                end else if (ctr_q[up_idx] != '0) begin
                    ctr_q[up_idx] <= ctr_q[up_idx] - CTR_W'(1);
                end
            end else if (upd_taken) begin
                valid_q[up_idx]  <= 1'b1;
                tag_q[up_idx]    <= up_tag;
                target_q[up_idx] <= upd_target;
                ctr_q[up_idx]    <= CtrWeak;
            end
            if (branch_count != '1) begin
                branch_count <= branch_count + CNT_W'(1);
            end
            if (mispredict && (mispred_count != '1)) begin
                mispred_count <= mispred_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_btb_bimodal_predictor.sv
// Self-checking bench: directed vector table, corner sequences and a randomized run
// against a behavioural model of the predictor.
module tb_btb_bimodal_predictor;

    localparam int unsigned AW = 32;
    localparam int unsigned EN = 16;
    localparam int unsigned CW = 2;
    localparam int unsigned NW = 4;
    localparam int unsigned CNT_MAX = (1 << NW) - 1;
    localparam int unsigned CTR_MAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] if_pc;
    logic          pred_taken;
    logic [AW-1:0] pred_target;
    logic          upd_valid;
    logic [AW-1:0] upd_pc;
    logic          upd_taken;
    logic [AW-1:0] upd_target;
    logic          upd_pred_taken;
    logic [AW-1:0] upd_pred_target;
    logic          mispredict;
    logic [AW-1:0] redirect_addr;
    logic [NW-1:0] branch_count;
    logic [NW-1:0] mispred_count;

    btb_bimodal_predictor #(
        .ADDR_W  (AW),
        .ENTRIES (EN),
        .CTR_W   (CW),
        .CNT_W   (NW)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .if_pc           (if_pc),
        .pred_taken      (pred_taken),
        .pred_target     (pred_target),
        .upd_valid       (upd_valid),
        .upd_pc          (upd_pc),
        .upd_taken       (upd_taken),
        .upd_target      (upd_target),
        .upd_pred_taken  (upd_pred_taken),
        .upd_pred_target (upd_pred_target),
        .mispredict      (mispredict),
        .redirect_addr   (redirect_addr),
        .branch_count    (branch_count),
        .mispred_count   (mispred_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit          m_valid [EN];
    int unsigned m_tag   [EN];
    logic [31:0] m_tgt   [EN];
    int unsigned m_ctr   [EN];
    int unsigned m_bc, m_mc;

    function automatic int unsigned midx(input logic [31:0] pc);
        return (pc / 4) % EN;
    endfunction

    function automatic int unsigned mtag(input logic [31:0] pc);
        return pc / (4 * EN);
    endfunction

    function automatic bit m_hit(input logic [31:0] pc);
        return m_valid[midx(pc)] && (m_tag[midx(pc)] == mtag(pc));
    endfunction

    // Predict taken when the counter sits in the upper half of its range.
    function automatic bit m_pt(input logic [31:0] pc);
        return m_hit(pc) && (m_ctr[midx(pc)] >= (CTR_MAX + 1) / 2);
    endfunction

    function automatic logic [31:0] m_ptgt(input logic [31:0] pc);
        return m_pt(pc) ? m_tgt[midx(pc)] : pc + 32'd4;
    endfunction

    function automatic bit m_mp();
        if (!upd_valid) return 1'b0;
        if (upd_pred_taken != upd_taken) return 1'b1;
        return upd_taken && (upd_pred_target != upd_target);
    endfunction

    task automatic m_clear();
        for (int i = 0; i < EN; i++) begin
            m_valid[i] = 1'b0;
            m_tag[i]   = 0;
            m_tgt[i]   = '0;
            m_ctr[i]   = 0;
        end
        m_bc = 0;
        m_mc = 0;
    endtask

    task automatic m_step();
        int unsigned i;
        if (!upd_valid) return;
        i = midx(upd_pc);
        if (m_mp() && m_mc < CNT_MAX) m_mc++;
        if (m_bc < CNT_MAX) m_bc++;
        if (m_hit(upd_pc)) begin
            if (upd_taken) begin
                if (m_ctr[i] < CTR_MAX) m_ctr[i]++;
                m_tgt[i] = upd_target;
            end else if (m_ctr[i] > 0) begin
                m_ctr[i]--;
            end
        end else if (upd_taken) begin
            m_valid[i] = 1'b1;
            m_tag[i]   = mtag(upd_pc);
            m_tgt[i]   = upd_target;
            m_ctr[i]   = (CTR_MAX + 1) / 2;
        end
    endtask

    // ---------------- directed vectors ----------------
    typedef struct {
        logic [31:0] ipc;
        logic        uv;
        logic [31:0] upc;
        logic        ut;
        logic [31:0] utgt;
        logic        upt;
        logic [31:0] uptgt;
        logic        ept;
        logic [31:0] eptgt;
        logic        emp;
        logic [31:0] eredir;
    } vec_t;

    vec_t vt[$];

    function automatic vec_t mkv(input logic [31:0] ipc, input logic uv, input logic [31:0] upc,
                                 input logic ut, input logic [31:0] utgt, input logic upt,
                                 input logic [31:0] uptgt, input logic ept,
                                 input logic [31:0] eptgt, input logic emp,
                                 input logic [31:0] eredir);
        vec_t v;
        v.ipc = ipc; v.uv = uv; v.upc = upc; v.ut = ut; v.utgt = utgt;
        v.upt = upt; v.uptgt = uptgt; v.ept = ept; v.eptgt = eptgt;
        v.emp = emp; v.eredir = eredir;
        return v;
    endfunction

    task automatic drive(input logic uv, input logic [31:0] upc, input logic ut,
                         input logic [31:0] utgt, input logic upt, input logic [31:0] uptgt);
        upd_valid       = uv;
        upd_pc          = upc;
        upd_taken       = ut;
        upd_target      = utgt;
        upd_pred_taken  = upt;
        upd_pred_target = uptgt;
    endtask

    function automatic logic [31:0] rnd_pc();
        logic [31:0] p;
        if ($urandom_range(0, 9) == 0) p = $urandom;
        else p = ($urandom_range(0, 3) << 6) | ($urandom_range(0, 15) << 2) | $urandom_range(0, 3);
        return p;
    endfunction

    initial begin
        rst = 1'b0;
        if_pc = 32'h0;
        drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        m_clear();
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;

        @(negedge clk);
        chk("reset_branch_count", 32'(branch_count), 32'd0);
        chk("reset_mispred_count", 32'(mispred_count), 32'd0);
        chk("reset_pred_taken", 32'(pred_taken), 32'd0);
        chk("reset_pred_target", pred_target, 32'h4);
        @(posedge clk);
        #1;

        // ipc uv upc ut utgt upt uptgt | ept eptgt emp eredir
        vt.push_back(mkv(32'h40, 1, 32'h40, 1, 32'h100, 0, 32'h44,  0, 32'h44,  1, 32'h100));
        vt.push_back(mkv(32'h40, 0, 32'h0,  0, 32'h0,   0, 32'h0,   1, 32'h100, 0, 32'h0));
        vt.push_back(mkv(32'h40, 1, 32'h40, 0, 32'h0,   1, 32'h100, 1, 32'h100, 1, 32'h44));
        vt.push_back(mkv(32'h40, 1, 32'h40, 1, 32'h100, 0, 32'h44,  0, 32'h44,  1, 32'h100));
        vt.push_back(mkv(32'h40, 1, 32'h40, 1, 32'h100, 1, 32'h100, 1, 32'h100, 0, 32'h0));
        vt.push_back(mkv(32'h40, 1, 32'h40, 0, 32'h0,   1, 32'h100, 1, 32'h100, 1, 32'h44));
        vt.push_back(mkv(32'h40, 0, 32'h0,  0, 32'h0,   0, 32'h0,   1, 32'h100, 0, 32'h0));
        vt.push_back(mkv(32'h40, 1, 32'h40, 1, 32'h100, 1, 32'h100, 1, 32'h100, 0, 32'h0));
        vt.push_back(mkv(32'h40, 1, 32'h40, 1, 32'h100, 1, 32'h100, 1, 32'h100, 0, 32'h0));
        vt.push_back(mkv(32'h40, 1, 32'h40, 0, 32'h0,   1, 32'h100, 1, 32'h100, 1, 32'h44));
        vt.push_back(mkv(32'h40, 0, 32'h0,  0, 32'h0,   0, 32'h0,   1, 32'h100, 0, 32'h0));
        vt.push_back(mkv(32'h440, 1, 32'h440, 1, 32'h200, 0, 32'h444, 0, 32'h444, 1, 32'h200));
        vt.push_back(mkv(32'h40, 0, 32'h0,  0, 32'h0,   0, 32'h0,   0, 32'h44,  0, 32'h0));
        vt.push_back(mkv(32'h440, 0, 32'h0, 0, 32'h0,   0, 32'h0,   1, 32'h200, 0, 32'h0));
        vt.push_back(mkv(32'h80, 1, 32'h80, 1, 32'h300, 0, 32'h84,  0, 32'h84,  1, 32'h300));
        vt.push_back(mkv(32'h80, 1, 32'h80, 1, 32'h380, 1, 32'h300, 1, 32'h300, 1, 32'h380));
        vt.push_back(mkv(32'h80, 0, 32'h0,  0, 32'h0,   0, 32'h0,   1, 32'h380, 0, 32'h0));
        vt.push_back(mkv(32'h80, 0, 32'hC4, 1, 32'h500, 0, 32'hC8,  1, 32'h380, 0, 32'h0));
        vt.push_back(mkv(32'hC4, 0, 32'h0,  0, 32'h0,   0, 32'h0,   0, 32'hC8,  0, 32'h0));
        vt.push_back(mkv(32'h82, 0, 32'h0,  0, 32'h0,   0, 32'h0,   1, 32'h380, 0, 32'h0));
        vt.push_back(mkv(32'hC4, 1, 32'hC4, 0, 32'h0,   0, 32'h0,   0, 32'hC8,  0, 32'h0));
        vt.push_back(mkv(32'hC4, 0, 32'h0,  0, 32'h0,   0, 32'h0,   0, 32'hC8,  0, 32'h0));
        vt.push_back(mkv(32'hFFFFFFFC, 0, 32'h0, 0, 32'h0, 0, 32'h0, 0, 32'h0,  0, 32'h0));

        foreach (vt[k]) begin
            if_pc = vt[k].ipc;
            drive(vt[k].uv, vt[k].upc, vt[k].ut, vt[k].utgt, vt[k].upt, vt[k].uptgt);
            @(negedge clk);
            chk($sformatf("vec%0d_pred_taken", k), 32'(pred_taken), 32'(vt[k].ept));
            chk($sformatf("vec%0d_pred_target", k), pred_target, vt[k].eptgt);
            chk($sformatf("vec%0d_mispredict", k), 32'(mispredict), 32'(vt[k].emp));
            if (vt[k].emp) chk($sformatf("vec%0d_redirect", k), redirect_addr, vt[k].eredir);
            @(posedge clk);
            #1;
        end
        drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        @(negedge clk);
        chk("table_branch_count", 32'(branch_count), 32'd12);
        chk("table_mispred_count", 32'(mispred_count), 32'd8);

        // Mispredicting not-taken misses: statistics saturate at 15, no state change.
        for (int n = 0; n < 20; n++) begin
            @(posedge clk);
            #1 drive(1'b1, 32'h200, 1'b0, 32'h0, 1'b1, 32'h600);
            if (n == 3) begin
                @(negedge clk);
                chk("sat_mid_branch_count", 32'(branch_count), 32'd15);
                chk("sat_mid_mispred_count", 32'(mispred_count), 32'd11);
            end
        end
        @(posedge clk);
        #1 drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        if_pc = 32'h80;
        @(negedge clk);
        chk("sat_branch_count", 32'(branch_count), 32'd15);
        chk("sat_mispred_count", 32'(mispred_count), 32'd15);
        chk("populated_pred_taken", 32'(pred_taken), 32'd1);

        // Asynchronous reset mid-cycle with entries populated.
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        chk("async_rst_pred_taken", 32'(pred_taken), 32'd0);
        chk("async_rst_pred_target", pred_target, 32'h84);
        chk("async_rst_branch_count", 32'(branch_count), 32'd0);
        chk("async_rst_mispred_count", 32'(mispred_count), 32'd0);
        if_pc = 32'h440;
        #1;
        chk("async_rst_pred_target2", pred_target, 32'h444);
        @(posedge clk);
        #1 rst = 1'b1;
        if_pc = 32'h80;
        @(negedge clk);
        chk("post_rst_branch_count", 32'(branch_count), 32'd0);
        chk("post_rst_mispred_count", 32'(mispred_count), 32'd0);
        chk("post_rst_pred_taken", 32'(pred_taken), 32'd0);
        m_clear();
        @(posedge clk);
        #1;

        // Randomized run against the behavioural model.
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) begin
                rst = 1'b0;
                m_clear();
                #2 rst = 1'b1;
            end
            if_pc = rnd_pc();
            upd_valid  = ($urandom_range(0, 3) != 0);
            upd_pc     = rnd_pc();
            upd_taken  = 1'($urandom_range(0, 1));
            upd_target = 32'h1000 + $urandom_range(0, 7) * 16;
            if ($urandom_range(0, 1) == 1) begin
                upd_pred_taken  = m_pt(upd_pc);
                upd_pred_target = m_ptgt(upd_pc);
            end else begin
                upd_pred_taken  = 1'($urandom_range(0, 1));
                upd_pred_target = 32'h1000 + $urandom_range(0, 7) * 16;
            end
            @(negedge clk);
            chk("rnd_pred_taken", 32'(pred_taken), 32'(m_pt(if_pc)));
            chk("rnd_pred_target", pred_target, m_ptgt(if_pc));
            chk("rnd_mispredict", 32'(mispredict), 32'(m_mp()));
            if (m_mp()) chk("rnd_redirect", redirect_addr,
                            upd_taken ? upd_target : upd_pc + 32'd4);
            chk("rnd_branch_count", 32'(branch_count), m_bc);
            chk("rnd_mispred_count", 32'(mispred_count), m_mc);
            @(posedge clk);
            m_step();
            #1;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
